// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: single-cycle CPU data port serving word RAM plus an LED/cycle/timer/tx-FIFO MMIO page
// Ports:
//   clk, reset (async active-low)
//   MemWrite, Mem_WrAddr, Mem_WrData : CPU store strobe, byte address, store data
//   ReadData                         : combinational load data for Mem_WrAddr
//   leds, timer_irq                  : LED register, sticky compare-hit flag
//   tx_data, tx_valid, tx_ready      : console sink handshake fed by the 4-entry byte FIFO
module dmem_mmio_responder #(
  parameter logic [31:0] RAM_BASE  = 32'h1000_0000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h2000_0000,
  parameter int          LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic [31:0]      Mem_WrAddr,
  input  logic [31:0]      Mem_WrData,
  output logic [31:0]      ReadData,
  output logic [LED_W-1:0] leds,
  output logic             timer_irq,
  output logic [7:0]       tx_data,
  output logic             tx_valid,
  input  logic             tx_ready
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] ram [RAM_WORDS];
  logic [7:0]  fifo [4];
  logic [31:0] ram_off, mmio_off, cycle, cmp, mmio_rd;
  logic [2:0]  reg_sel, count;
  logic [1:0]  wp, rp;
  logic        ram_hit, mmio_hit, wr, st_wr, hit, ovf, full, empty, push_req, push, pop;
  // Offset subtraction wraps for addresses below the base, so one unsigned compare covers both bounds.
  assign ram_off   = Mem_WrAddr - RAM_BASE;
  assign mmio_off  = Mem_WrAddr - MMIO_BASE;
  assign ram_hit   = ram_off < 32'(4 * RAM_WORDS);
  assign mmio_hit  = mmio_off < 32'd32;
  assign reg_sel   = mmio_off[4:2];
  assign wr        = MemWrite && mmio_hit;
  assign st_wr     = wr && reg_sel == 3'd3;
  assign full      = count == 3'd4;
  assign empty     = count == 3'd0;
  // Full is judged before any same-cycle pop, so a push into a full FIFO is always dropped.
  assign push_req  = wr && reg_sel == 3'd4;
  assign push      = push_req && !full;
  assign pop       = !empty && tx_ready;
  assign tx_valid  = !empty;
  assign tx_data   = empty ? 8'h00 : fifo[rp];
  assign timer_irq = hit;
  always_comb begin
    mmio_rd  = reg_sel == 3'd0 ? 32'(leds) :
               reg_sel == 3'd1 ? cycle :
               reg_sel == 3'd2 ? cmp :
               reg_sel == 3'd3 ? {25'b0, count, ovf, empty, full, hit} : 32'h0;
    ReadData = ram_hit ? ram[Mem_WrAddr[AW+1:2]] : mmio_hit ? mmio_rd : 32'h0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      leds  <= '0;
      cycle <= '0;
      cmp   <= '1;
      hit   <= 1'b0;
      ovf   <= 1'b0;
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      // Set beats a same-cycle W1C clear.
      hit   <= (cycle == cmp) || (hit && !(st_wr && Mem_WrData[0]));
      ovf   <= (push_req && full) || (ovf && !(st_wr && Mem_WrData[3]));
      if (wr && reg_sel == 3'd0) leds <= Mem_WrData[LED_W-1:0];
      if (wr && reg_sel == 3'd2) cmp <= Mem_WrData;
      if (push) wp <= wp + 2'd1;
      if (pop) rp <= rp + 2'd1;
      count <= count + 3'(push) - 3'(pop);
    end
  // Storage arrays carry no reset; the FIFO count alone decides validity.
  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) ram[Mem_WrAddr[AW+1:2]] <= Mem_WrData;
    if (push) fifo[wp] <= Mem_WrData[7:0];
  end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed literal checks plus randomized traffic against a queue/array reference model
module tb_dmem_mmio_responder;
  localparam logic [31:0] RAM_BASE  = 32'h1000_0000;
  localparam int          RAM_WORDS = 1024;
  localparam logic [31:0] MMIO_BASE = 32'h2000_0000;
  localparam int          LED_W     = 8;
  logic             clk = 1'b0;
  logic             reset;
  logic             MemWrite = 1'b0;
  logic [31:0]      Mem_WrAddr = '0;
  logic [31:0]      Mem_WrData = '0;
  logic [31:0]      ReadData;
  logic [LED_W-1:0] leds;
  logic             timer_irq;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready = 1'b0;
  int tests = 0;
  int fails = 0;
  dmem_mmio_responder #(.RAM_BASE(RAM_BASE), .RAM_WORDS(RAM_WORDS), .MMIO_BASE(MMIO_BASE), .LED_W(LED_W)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .Mem_WrAddr(Mem_WrAddr), .Mem_WrData(Mem_WrData),
    .ReadData(ReadData), .leds(leds), .timer_irq(timer_irq), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready)
  );
  always #5 clk = ~clk;
  // Reference model state
  logic [LED_W-1:0] mleds;
  logic [31:0]      mcycle, mcmp;
  bit               mhit, movf;
  logic [7:0]       mq[$];
  logic [31:0]      mram[int];
  function automatic bit in_ram(input logic [31:0] a);
    longint x = longint'(a);
    return x >= longint'(RAM_BASE) && x < longint'(RAM_BASE) + 4 * RAM_WORDS;
  endfunction
  function automatic bit in_mmio(input logic [31:0] a);
    longint x = longint'(a);
    return x >= longint'(MMIO_BASE) && x < longint'(MMIO_BASE) + 32;
  endfunction
  function automatic int ridx(input logic [31:0] a);
    return int'((longint'(a) - longint'(RAM_BASE)) / 4);
  endfunction
  function automatic int moff(input logic [31:0] a);
    return int'((longint'(a) - longint'(MMIO_BASE)) / 4) * 4;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mleds = '0; mcycle = '0; mcmp = '1; mhit = 0; movf = 0;
      mq.delete();
    end else begin
      bit st, was_full, nhit, novf;
      int o;
      st = MemWrite && in_mmio(Mem_WrAddr);
      o = moff(Mem_WrAddr);
      was_full = mq.size() == 4;
      nhit = (mcycle == mcmp) || (mhit && !(st && o == 12 && Mem_WrData[0]));
      novf = (st && o == 16 && was_full) || (movf && !(st && o == 12 && Mem_WrData[3]));
      if (mq.size() > 0 && tx_ready) void'(mq.pop_front());
      if (st && o == 16 && !was_full) mq.push_back(Mem_WrData[7:0]);
      if (st && o == 0) mleds = Mem_WrData[LED_W-1:0];
      if (st && o == 8) mcmp = Mem_WrData;
      if (MemWrite && in_ram(Mem_WrAddr)) mram[ridx(Mem_WrAddr)] = Mem_WrData;
      mhit = nhit;
      movf = novf;
      mcycle = mcycle + 1;
    end
  end
  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      int n;
      logic [31:0] exp_rd;
      n = mq.size();
      chk("leds", 32'(leds), 32'(mleds));
      chk("timer_irq", 32'(timer_irq), 32'(mhit));
      chk("tx_valid", 32'(tx_valid), 32'(n > 0));
      chk("tx_data", 32'(tx_data), n > 0 ? 32'(mq[0]) : 32'h0);
      if (in_ram(Mem_WrAddr)) begin
        if (mram.exists(ridx(Mem_WrAddr))) chk("rd_ram", ReadData, mram[ridx(Mem_WrAddr)]);
      end else begin
        exp_rd = 32'h0;
        if (in_mmio(Mem_WrAddr))
          case (moff(Mem_WrAddr))
            0: exp_rd = 32'(mleds);
            4: exp_rd = mcycle;
            8: exp_rd = mcmp;
            12: exp_rd = 32'(n * 16 + int'(movf) * 8 + int'(n == 0) * 4 + int'(n == 4) * 2 + int'(mhit));
            default: exp_rd = 32'h0;
          endcase
        chk("rd_mmio", ReadData, exp_rd);
      end
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic store(input logic [31:0] a, input logic [31:0] d);
    Mem_WrAddr = a; Mem_WrData = d; MemWrite = 1'b1;
    step();
    MemWrite = 1'b0;
  endtask
  function automatic logic [31:0] pick_addr();
    logic [31:0] a;
    case ($urandom_range(0, 5))
      0, 1: a = MMIO_BASE + 4 * $urandom_range(0, 7);
      2: a = RAM_BASE + 4 * $urandom_range(0, 7);
      3: a = RAM_BASE + 4 * (RAM_WORDS - 1 - $urandom_range(0, 1));
      4: case ($urandom_range(0, 5))
           0: a = RAM_BASE - 4;
           1: a = RAM_BASE + 4 * RAM_WORDS;
           2: a = MMIO_BASE - 4;
           3: a = MMIO_BASE + 32;
           4: a = 32'h3000_0000;
           default: a = 32'h0;
         endcase
      default: a = MMIO_BASE + 16;
    endcase
    return a | 32'($urandom_range(0, 3));
  endfunction
  string msg = "ABCDE";
  initial begin
    reset = 1'b0;
    #12 reset = 1'b1;
    @(posedge clk); #1;
    Mem_WrAddr = MMIO_BASE + 4; #1;
    chk("cycle_first", ReadData, 32'd1);
    Mem_WrAddr = MMIO_BASE; #1;
    chk("led_reset", ReadData, 32'h0);
    Mem_WrAddr = MMIO_BASE + 8; #1;
    chk("cmp_reset", ReadData, 32'hFFFF_FFFF);
    Mem_WrAddr = MMIO_BASE + 12; #1;
    chk("status_reset", ReadData, 32'h4);
    chk("tx_valid_reset", 32'(tx_valid), 32'h0);
    chk("irq_reset", 32'(timer_irq), 32'h0);
    store(RAM_BASE + 32'h10, 32'hDEAD_BEEF);
    #1 chk("ram_rb", ReadData, 32'hDEAD_BEEF);
    Mem_WrAddr = 32'h3000_0000; #1;
    chk("unmapped", ReadData, 32'h0);
    store(MMIO_BASE, 32'h1A5);
    chk("leds_a5", 32'(leds), 32'hA5);
    store(MMIO_BASE + 8, mcycle + 5);
    for (int i = 1; i <= 4; i++) begin
      chk("irq_early", 32'(timer_irq), 32'h0);
      step();
    end
    chk("irq_early", 32'(timer_irq), 32'h0);
    step();
    chk("irq_rise", 32'(timer_irq), 32'h1);
    step();
    chk("irq_sticky", 32'(timer_irq), 32'h1);
    store(MMIO_BASE + 12, 32'h1);
    chk("irq_clear", 32'(timer_irq), 32'h0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(MMIO_BASE + 16, 32'(msg[i]));
    Mem_WrAddr = MMIO_BASE + 12; #1;
    chk("status_full_ovf", ReadData, 32'h4A);
    chk("head_A", 32'(tx_data), 32'h41);
    store(MMIO_BASE + 12, 32'h8);
    tx_ready = 1'b1; #1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_seq", 32'(tx_data), 32'h41 + 32'(i));
      chk("drain_valid", 32'(tx_valid), 32'h1);
      step();
    end
    chk("drain_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    Mem_WrAddr = MMIO_BASE + 12; #1;
    chk("ovf_cleared", ReadData, 32'h4);
    store(MMIO_BASE + 16, 32'h11);
    store(MMIO_BASE + 16, 32'h22);
    Mem_WrAddr = MMIO_BASE + 16; Mem_WrData = 32'h33; MemWrite = 1'b1; tx_ready = 1'b1; #1;
    chk("pp_head", 32'(tx_data), 32'h11);
    step();
    MemWrite = 1'b0; tx_ready = 1'b0; Mem_WrAddr = MMIO_BASE + 12; #1;
    chk("pp_count2", ReadData, 32'h20);
    chk("pp_next", 32'(tx_data), 32'h22);
    tx_ready = 1'b1;
    step();
    chk("pp_last", 32'(tx_data), 32'h33);
    step();
    chk("pp_empty", 32'(tx_valid), 32'h0);
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) store(MMIO_BASE + 16, 32'h60 + 32'(i));
    tx_ready = 1'b1; step();
    tx_ready = 1'b0; step();
    tx_ready = 1'b1;
    #3 reset = 1'b0;
    #1;
    chk("rst_tx_valid", 32'(tx_valid), 32'h0);
    chk("rst_tx_data", 32'(tx_data), 32'h0);
    chk("rst_irq", 32'(timer_irq), 32'h0);
    step();
    tx_ready = 1'b0;
    step();
    reset = 1'b1;
    Mem_WrAddr = MMIO_BASE + 12; #1;
    chk("rst_status", ReadData, 32'h4);
    chk("rst_leds", 32'(leds), 32'h0);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] a;
      a = pick_addr();
      Mem_WrAddr = a;
      MemWrite = $urandom_range(0, 1) == 1;
      Mem_WrData = (a & ~32'h3) == MMIO_BASE + 8 ? mcycle + 32'($urandom_range(0, 6)) : $urandom;
      tx_ready = i < 1500 ? $urandom_range(0, 3) == 0 : $urandom_range(0, 3) != 0;
      step();
    end
    MemWrite = 1'b0;
    step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
